// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared defaults and state encoding for the round-robin mux arbiter
package mux_arb_pkg;
  localparam int N_REQ_DEF = 16;
  localparam int SEL_W_DEF = 4;
  localparam int HOLD_MAX_DEF = 4;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: finds the first set request at or above ptr, wrapping modulo N_REQ
module rr_pick #(
  parameter int N_REQ = 16,
  parameter int SEL_W = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    found = |rot;
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) if (rot[k]) off = SEL_W'(k);
    idx = ptr + off;
  end
endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter granting one requester a burst of up to HOLD_MAX beats
module mux16_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] in,
  input  logic             out_ready,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             out_data
);
  state_t state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, idx;
  logic [3:0] cnt_q, cnt_d;
  logic found, xfer;

  rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick (
    .req(req), .ptr(ptr_q), .found(found), .idx(idx)
  );

  assign gnt = gnt_q;
  assign sel = sel_q;
  assign out_valid = (state_q == BUSY) && req[sel_q];
  assign out_data = in[sel_q];
  assign xfer = out_valid && out_ready;

  // A dropped request ends the burst without a beat; the last allowed beat ends it with one.
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = BUSY;
        gnt_d = N_REQ'(1) << idx;
        sel_d = idx;
        cnt_d = '0;
      end
    end else if (!req[sel_q] || (xfer && cnt_q == 4'(HOLD_MAX - 1))) begin
      state_d = IDLE;
      gnt_d = '0;
      ptr_d = sel_q + SEL_W'(1);
    end else if (xfer) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed vector table plus a hand-written reset-mid-burst sequence
module tb_mux16_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] req, din;
  logic out_ready;
  logic [15:0] gnt;
  logic [3:0] sel;
  logic out_valid, out_data;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic r;
    logic [15:0] rq;
    logic [15:0] dn;
    logic rd;
    logic [15:0] g;
    logic [3:0] s;
    logic ov;
    logic od;
  } vec_t;

  vec_t vecs[$];

  mux16_rr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in(din), .out_ready(out_ready),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [15:0] rq, logic [15:0] dn, logic rd,
                              logic [15:0] g, logic [3:0] s, logic ov, logic od);
    vec_t v;
    v.r = r; v.rq = rq; v.dn = dn; v.rd = rd; v.g = g; v.s = s; v.ov = ov; v.od = od;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; din = '0; out_ready = 1'b0;
    // single requester, then ptr=5 check via a 4/5 tie
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0010, 16'h0010, 1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 16'h0010, 16'h0010, 1, 16'h0010, 4, 1, 1));
    vecs.push_back(mk(1, 16'h0030, 0, 1, 0, 4, 0, 0));
    vecs.push_back(mk(1, 16'h0030, 16'h0020, 0, 16'h0020, 5, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0020, 5, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 5, 0, 0));
    // fairness 0 / 15
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h8001, 16'h8001, 1, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 16'h8001, 16'h8001, 1, 16'h0001, 0, 1, 1));
    vecs.push_back(mk(1, 16'h8001, 16'h8001, 1, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 16'h8001, 16'h8001, 1, 16'h8000, 15, 1, 1));
    vecs.push_back(mk(1, 16'h8001, 16'h8001, 1, 0, 15, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 16'h8001, 16'h8001, 1, 16'h0001, 0, 1, 1));
    vecs.push_back(mk(1, 16'h8001, 16'h8001, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h8001, 16'h8001, 1, 16'h8000, 15, 1, 1));
    // backpressure on 2
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0004, 16'h0004, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 16'h0004, 16'h0004, 0, 16'h0004, 2, 1, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 16'h0004, 16'h0004, 1, 16'h0004, 2, 1, 1));
    vecs.push_back(mk(1, 16'h0004, 16'h0004, 1, 0, 2, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0004, 1, 16'h0004, 2, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0004, 1, 0, 2, 0, 1));
    // early release on 7, then wrap from ptr=14
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0080, 16'h0080, 1, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1, 16'h0080, 16'h0080, 1, 16'h0080, 7, 1, 1));
    vecs.push_back(mk(1, 0, 16'h0080, 1, 16'h0080, 7, 0, 1));
    vecs.push_back(mk(1, 16'h0180, 0, 1, 0, 7, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0100, 8, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 8, 0, 0));
    vecs.push_back(mk(1, 16'h2000, 0, 1, 0, 8, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h2000, 13, 0, 0));
    vecs.push_back(mk(1, 16'h0003, 0, 1, 0, 13, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 16'h0001, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].r; req = vecs[i].rq; din = vecs[i].dn; out_ready = vecs[i].rd;
      #1;
      chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].g));
      chk($sformatf("row%0d sel", i), 32'(sel), 32'(vecs[i].s));
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(vecs[i].od));
    end
    // reset during beat 2 of a grant to 9
    @(negedge clk);
    rst_n = 1'b0; req = '0; din = '0;
    @(negedge clk);
    rst_n = 1'b1; req = 16'h0200; din = 16'h0200; out_ready = 1'b1;
    @(negedge clk);
    chk("mid gnt9", 32'(gnt), 32'h0200);
    chk("mid valid9", 32'(out_valid), 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async gnt", 32'(gnt), 32'h0);
    chk("async valid", 32'(out_valid), 32'h0);
    chk("async sel", 32'(sel), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; req = 16'h0202; din = '0;
    #1;
    chk("post rst gnt", 32'(gnt), 32'h0);
    chk("post rst valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    chk("post rst grant1", 32'(gnt), 32'h0002);
    chk("post rst sel1", 32'(sel), 32'h1);
    chk("post rst valid1", 32'(out_valid), 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
